// File: rtl/seq_fsm_pkg.sv
// Shared encodings for the 11011-preamble link: FSM state codes and the preamble constant.
// The receive-side detector reuses PREAMBLE_11011/PREAMBLE_W so both ends agree on the pattern.
package seq_fsm_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_PRE  = S_PRE,
    ST_DATA = S_DATA,
    ST_PAR  = S_PAR,
    ST_GAP  = S_GAP
  } state_t;

  localparam int                    PREAMBLE_W     = 5;
  localparam logic [PREAMBLE_W-1:0] PREAMBLE_11011 = 5'b11011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload handshake into the serial transmitter: valid/ready word plus synchronous flush.
// master drives the payload side, slave is the transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;

  modport master (output in_valid, output in_data, output flush, input in_ready);
  modport slave  (input in_valid, input in_data, input flush, output in_ready);
endinterface

// File: rtl/seq_piso.sv
// Payload parallel-in/serial-out register: load on accept, shift MSB-first, clear on abort.
// msb is the next payload bit; with SEQ_TX_PARITY_EN the even parity of the load is held alongside.
module seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] din,
`ifdef SEQ_TX_PARITY_EN
  output logic         par,
`endif
  output logic         msb
);

  logic [W-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (clear) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[W-1];

`ifdef SEQ_TX_PARITY_EN
  // Parity is latched at load because the shift register no longer holds the word by the PAR bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (clear) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^din;
    end
  end
`endif

endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serialises preamble, payload and (SEQ_TX_PARITY_EN) even parity MSB-first on out.
// First bit appears the cycle after accept; in_ready only in IDLE, so a frame is never re-sampled.
module seq_frame_tx
  import seq_fsm_pkg::*;
#(
  parameter int                PAT_W    = PREAMBLE_W,
  parameter logic [PAT_W-1:0]  PATTERN  = PREAMBLE_11011,
  parameter int                DATA_W   = 8,
  parameter int                IDLE_GAP = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_frame_tx_if.slave  bus,
  output logic           out,
  output logic           out_vld,
  output logic           frame_done
);

  localparam int CNT_W = $clog2(max3(PAT_W, DATA_W, IDLE_GAP) + 1);
`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit DONE_ON_DATA_ENTRY = !PAR_EN && (DATA_W == 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [PAT_W-1:0] pre_sr;
  logic             accept;
  logic             abort;
  logic             piso_shift;
  logic             piso_msb;
`ifdef SEQ_TX_PARITY_EN
  logic             piso_par;
`endif

  assign bus.in_ready = (state == ST_IDLE) && rst_n;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign abort        = bus.flush && (state != ST_IDLE);
  // Shift whenever a payload bit is moved onto out so msb always presents the next one.
  assign piso_shift   = ((state == ST_PRE) && (bit_cnt == '0)) ||
                        ((state == ST_DATA) && (bit_cnt != '0));

  seq_piso #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (piso_shift),
    .clear (abort),
    .din   (bus.in_data),
`ifdef SEQ_TX_PARITY_EN
    .par   (piso_par),
`endif
    .msb   (piso_msb)
  );

  // bit_cnt holds the number of bits still to follow the one currently on out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      pre_sr     <= '0;
      out        <= 1'b0;
      out_vld    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state   <= ST_GAP;
        bit_cnt <= CNT_W'(IDLE_GAP - 1);
        out     <= 1'b0;
        out_vld <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            out     <= 1'b0;
            out_vld <= 1'b0;
            if (accept) begin
              state   <= ST_PRE;
              out     <= PATTERN[PAT_W-1];
              out_vld <= 1'b1;
              pre_sr  <= PATTERN << 1;
              bit_cnt <= CNT_W'(PAT_W - 1);
            end
          end
          ST_PRE: begin
            if (bit_cnt == '0) begin
              state      <= ST_DATA;
              out        <= piso_msb;
              bit_cnt    <= CNT_W'(DATA_W - 1);
              frame_done <= DONE_ON_DATA_ENTRY;
            end else begin
              out     <= pre_sr[PAT_W-1];
              pre_sr  <= pre_sr << 1;
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (bit_cnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
              state      <= ST_PAR;
              out        <= piso_par;
              frame_done <= 1'b1;
`else
              state   <= ST_GAP;
              out     <= 1'b0;
              out_vld <= 1'b0;
              bit_cnt <= CNT_W'(IDLE_GAP - 1);
`endif
            end else begin
              out        <= piso_msb;
              bit_cnt    <= bit_cnt - CNT_W'(1);
              frame_done <= !PAR_EN && (bit_cnt == CNT_W'(1));
            end
          end
`ifdef SEQ_TX_PARITY_EN
          ST_PAR: begin
            state   <= ST_GAP;
            out     <= 1'b0;
            out_vld <= 1'b0;
            bit_cnt <= CNT_W'(IDLE_GAP - 1);
          end
`endif
          ST_GAP: begin
            out     <= 1'b0;
            out_vld <= 1'b0;
            if (bit_cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            out     <= 1'b0;
            out_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: a symbol-stream model predicts every output cycle,
// a negedge monitor pops and compares, and a software 11011 detector checks the loopback.
module tb_seq_frame_tx;

  localparam int         PAT_W    = 5;
  localparam logic [4:0] PATTERN  = 5'b11011;
  localparam int         DATA_W   = 8;
  localparam int         IDLE_GAP = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int         PAR      = 1;
`else
  localparam int         PAR      = 0;
`endif

  typedef struct packed {
    logic vld;
    logic b;
    logic done;
    logic pre_end;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n;
  logic out;
  logic out_vld;
  logic frame_done;

  seq_frame_tx_if #(.DATA_W(DATA_W)) bus ();

  seq_frame_tx #(
    .PAT_W    (PAT_W),
    .PATTERN  (PATTERN),
    .DATA_W   (DATA_W),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .out        (out),
    .out_vld    (out_vld),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  sym_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         acc_cnt  = 0;
  bit         idle_now = 1'b1;
  bit         det_en   = 1'b0;
  int         det_hits = 0;
  logic [4:0] det_win  = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic push_gap();
    sym_t s;
    s = '0;
    for (int i = 0; i < IDLE_GAP; i++) exp_q.push_back(s);
  endtask

  // A frame is simply PATTERN, the payload word and its parity read left to right.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [PAT_W+DATA_W:0] frame;
    sym_t s;
    int n;
    frame = {PATTERN, d, ^d};
    n = PAT_W + DATA_W + PAR;
    for (int k = 0; k < n; k++) begin
      s.vld     = 1'b1;
      s.b       = frame[PAT_W+DATA_W-k];
      s.done    = (k == n - 1);
      s.pre_end = (k == PAT_W - 1);
      exp_q.push_back(s);
    end
    push_gap();
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.flush && !idle_now) begin
        exp_q.delete();
        push_gap();
      end else if (bus.in_valid && !bus.flush && idle_now) begin
        push_frame(bus.in_data);
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    sym_t e;
    logic hit;
    bit   exp_rdy;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      idle_now = 1'b1;
    end else begin
      exp_rdy  = (exp_q.size() == 0);
      idle_now = exp_rdy;
      if (exp_rdy) e = '0;
      else         e = exp_q.pop_front();
      chk("out",        out,          e.b);
      chk("out_vld",    out_vld,      e.vld);
      chk("frame_done", frame_done,   e.done);
      chk("in_ready",   bus.in_ready, exp_rdy);
      if (det_en) begin
        det_win = {det_win[3:0], out};
        hit     = (det_win == PATTERN);
        if (hit) begin
          det_win = '0;
          det_hits++;
        end
        chk("det_hit", hit, e.pre_end);
      end
    end
  end

  task automatic wait_accept(input int base);
    int t;
    t = 0;
    while (acc_cnt == base && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (acc_cnt == base) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=none want=accept t=%0t", $time);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int base;
    base = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    wait_accept(base);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((!idle_now || exp_q.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!idle_now) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy want=idle t=%0t", $time);
    end
  endtask

  initial begin
    int base;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",        out,          0);
    chk("rst_out_vld",    out_vld,      0);
    chk("rst_frame_done", frame_done,   0);
    chk("rst_in_ready",   bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single frames, including the parity vectors.
    send(8'hA5);
    wait_idle();
    send(8'h01);
    wait_idle();

    // in_valid held: back-to-back frames, payload scrambled mid-frame.
    base = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    wait_accept(base);
    repeat (5) begin
      bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_data = 8'hC3;
    wait_accept(base + 1);
    bus.in_valid = 1'b0;
    repeat (4) begin
      bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_idle();

    // Flush on the 3rd payload bit, then flush colliding with in_valid in IDLE.
    send(8'h5A);
    repeat (7) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    wait_idle();
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Loopback through the detector with all-zero payloads.
    det_en   = 1'b1;
    det_win  = '0;
    det_hits = 0;
    repeat (3) send(8'h00);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    det_en = 1'b0;
    chk("det_hits", det_hits, 3);

    // Random traffic with occasional flushes.
    repeat (600) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_data  = 8'($urandom);
      bus.flush    = ($urandom % 30) == 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    send(8'hE7);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out",        out,          0);
    chk("midrst_out_vld",    out_vld,      0);
    chk("midrst_frame_done", frame_done,   0);
    chk("midrst_in_ready",   bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", bus.in_ready, 1);
    send(8'h96);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
